// File: rtl/adc_clk_gen_pkg.sv
// rtl/adc_clk_gen_pkg.sv - shared defaults and types for the multi-channel ADC sample-clock generator
package adc_clk_gen_pkg;

  localparam int CW_DEFAULT       = 16;
  localparam int DEF_HALF_DEFAULT = 781;
  localparam int NCH_MAX          = 8;

  typedef logic [CW_DEFAULT-1:0] half_t;
  typedef logic [2:0]            ch_idx_t;

  // Channel-select width never drops below one bit, even for a single channel.
  function automatic int ch_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/adc_clk_gen_if.sv
// rtl/adc_clk_gen_if.sv - control/status bundle for adc_clk_gen; ADC_CLK_GEN_PHASE_EN adds wr_phase
interface adc_clk_gen_if
  import adc_clk_gen_pkg::*;
#(
  parameter int NCH = 2,
  parameter int CW  = CW_DEFAULT
) ();

  localparam int WCH = ch_width(NCH);

  logic [NCH-1:0] en;
  logic           sync;
  logic           wr;
  logic [WCH-1:0] wr_ch;
  logic [CW-1:0]  wr_half;
`ifdef ADC_CLK_GEN_PHASE_EN
  logic [CW-1:0]  wr_phase;
`endif
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pending;

  modport master (
    output en, sync, wr, wr_ch, wr_half,
`ifdef ADC_CLK_GEN_PHASE_EN
    output wr_phase,
`endif
    input  clk_out, tick, pending
  );

  modport slave (
    input  en, sync, wr, wr_ch, wr_half,
`ifdef ADC_CLK_GEN_PHASE_EN
    input  wr_phase,
`endif
    output clk_out, tick, pending
  );

endinterface

// File: rtl/adc_clk_gen_ch.sv
// rtl/adc_clk_gen_ch.sv - one divided-clock channel with boundary-staged half-period
// ADC_CLK_GEN_PHASE_EN adds a staged start phase loaded on restart.
module adc_clk_gen_ch
  import adc_clk_gen_pkg::*;
#(
  parameter int CW       = CW_DEFAULT,
  parameter int DEF_HALF = DEF_HALF_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic          i_sync,
  input  logic          i_wr,
  input  logic [CW-1:0] i_wr_half,
`ifdef ADC_CLK_GEN_PHASE_EN
  input  logic [CW-1:0] i_wr_phase,
`endif
  output logic          o_clk_out,
  output logic          o_tick,
  output logic          o_pending
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_half_act;
  logic [CW-1:0] r_half_pend;
  logic          r_pending;
  logic          r_clk_out;
  logic          r_tick;
  logic          r_en_q;

  logic          w_hit;
  logic          w_restart;
  logic          w_boundary;
  logic          w_apply;
  logic [CW-1:0] w_half_new;
  logic [CW-1:0] w_start;

  assign w_hit      = (r_cnt == r_half_act);
  assign w_restart  = i_sync | ~r_en_q;
  // Falling toggle is the only point where the active half-period may change.
  assign w_boundary = i_en & ~w_restart & w_hit & r_clk_out;
  assign w_apply    = ~i_en | i_sync | w_boundary;
  assign w_half_new = i_wr ? i_wr_half : (r_pending ? r_half_pend : r_half_act);

`ifdef ADC_CLK_GEN_PHASE_EN
  logic [CW-1:0] r_phase_act;
  logic [CW-1:0] r_phase_pend;
  logic [CW-1:0] w_phase_new;
  logic [CW-1:0] w_phase_eff;
  logic [CW-1:0] w_half_eff;

  assign w_phase_new = i_wr ? i_wr_phase : (r_pending ? r_phase_pend : r_phase_act);
  assign w_phase_eff = w_apply ? w_phase_new : r_phase_act;
  assign w_half_eff  = w_apply ? w_half_new  : r_half_act;
  assign w_start     = (w_phase_eff < w_half_eff) ? w_phase_eff : w_half_eff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase_act  <= '0;
      r_phase_pend <= '0;
    end else if (w_apply) begin
      r_phase_act  <= w_phase_new;
      r_phase_pend <= w_phase_new;
    end else if (i_wr) begin
      r_phase_pend <= i_wr_phase;
    end
  end
`else
  assign w_start = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_half_act  <= CW'(DEF_HALF);
      r_half_pend <= CW'(DEF_HALF);
      r_pending   <= 1'b0;
      r_clk_out   <= 1'b0;
      r_tick      <= 1'b0;
      r_en_q      <= 1'b0;
    end else begin
      r_en_q <= i_en;

      if (w_apply) begin
        r_half_act  <= w_half_new;
        r_half_pend <= w_half_new;
        r_pending   <= 1'b0;
      end else if (i_wr) begin
        r_half_pend <= i_wr_half;
        r_pending   <= 1'b1;
      end

      if (!i_en) begin
        r_cnt     <= '0;
        r_clk_out <= 1'b0;
        r_tick    <= 1'b0;
      end else if (w_restart) begin
        r_cnt     <= w_start;
        r_clk_out <= 1'b0;
        r_tick    <= 1'b0;
      end else if (w_hit) begin
        r_cnt     <= '0;
        r_clk_out <= ~r_clk_out;
        r_tick    <= ~r_clk_out;
      end else begin
        r_cnt     <= r_cnt + CW'(1);
        r_tick    <= 1'b0;
      end
    end
  end

  assign o_clk_out = r_clk_out;
  assign o_tick    = r_tick;
  assign o_pending = r_pending;

endmodule

// File: rtl/adc_clk_gen.sv
// rtl/adc_clk_gen.sv - NCH-channel ADC sample-clock generator; ADC_CLK_GEN_PHASE_EN enables start phase
module adc_clk_gen
  import adc_clk_gen_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int CW       = CW_DEFAULT,
  parameter int DEF_HALF = DEF_HALF_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  adc_clk_gen_if.slave bus
);

  localparam int WCH = ch_width(NCH);

  logic [NCH-1:0] w_wr;

  // Out-of-range wr_ch matches no generate index, so such writes are dropped.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_wr[g] = bus.wr && (bus.wr_ch == WCH'(g));

    adc_clk_gen_ch #(
      .CW       (CW),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_en       (bus.en[g]),
      .i_sync     (bus.sync),
      .i_wr       (w_wr[g]),
      .i_wr_half  (bus.wr_half),
`ifdef ADC_CLK_GEN_PHASE_EN
      .i_wr_phase (bus.wr_phase),
`endif
      .o_clk_out  (bus.clk_out[g]),
      .o_tick     (bus.tick[g]),
      .o_pending  (bus.pending[g])
    );
  end

endmodule

// File: tb/tb_adc_clk_gen.sv
// tb/tb_adc_clk_gen.sv - directed self-checking bench for adc_clk_gen (NCH=2, CW=16, half 781)
module tb_adc_clk_gen;
  import adc_clk_gen_pkg::*;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   n;
  int   hi;

  adc_clk_gen_if #(.NCH(2), .CW(16)) bus ();

  adc_clk_gen #(
    .NCH      (2),
    .CW       (16),
    .DEF_HALF (781)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts negedge samples until tick[ch] is seen; hi counts samples with clk_out[ch] high.
  task automatic wait_tick(input int ch, input int budget, output int cnt, output int high);
    cnt  = 0;
    high = 0;
    while (cnt < budget) begin
      @(negedge clk);
      cnt++;
      if (bus.clk_out[ch]) high++;
      if (bus.tick[ch]) break;
    end
  endtask

  task automatic write(input int ch, input int half);
    bus.wr      = 1'b1;
    bus.wr_ch   = 1'(ch);
    bus.wr_half = 16'(half);
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.en      = 2'b00;
    bus.sync    = 1'b0;
    bus.wr      = 1'b0;
    bus.wr_ch   = '0;
    bus.wr_half = '0;
    #1 rst = 1'b0;
    #4;
    chk("rst_clk_out", 32'(bus.clk_out), 0);
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_pending", 32'(bus.pending), 0);

    bus.en = 2'b11;
    @(negedge clk);
    rst = 1'b1;
    wait_tick(0, 2000, n, hi);
    chk("first_tick_lat", n, 783);
    chk("first_tick_hi", hi, 1);
    chk("first_tick_ch1", 32'(bus.tick[1]), 1);
    wait_tick(0, 2000, n, hi);
    chk("def_period", n, 1564);
    chk("def_high", hi, 782);

    write(1, 9);
    @(negedge clk);
    bus.wr = 1'b0;
    chk("wr_pending_set", 32'(bus.pending), 2);
    repeat (500) @(negedge clk);
    chk("wr_pending_hold", 32'(bus.pending), 2);
    wait_tick(1, 2000, n, hi);
    chk("old_period_done", n, 291);
    chk("wr_pending_clr", 32'(bus.pending), 0);
    wait_tick(1, 2000, n, hi);
    chk("new_period", n, 20);
    chk("new_high", hi, 10);
    wait_tick(0, 2000, n, hi);
    chk("ch0_unaffected", n, 752);

    wait_tick(1, 100, n, hi);
    chk("ch1_phase", n, 8);
    write(1, 4);
    @(negedge clk);
    bus.wr_half = 16'd6;
    @(negedge clk);
    bus.wr = 1'b0;
    wait_tick(1, 100, n, hi);
    chk("lastwin_first", n, 15);
    chk("lastwin_pending", 32'(bus.pending[1]), 0);
    wait_tick(1, 100, n, hi);
    chk("lastwin_period", n, 14);
    chk("lastwin_high", hi, 7);

    write(1, 0);
    @(negedge clk);
    bus.wr = 1'b0;
    wait_tick(1, 100, n, hi);
    chk("half0_first", n, 7);
    wait_tick(1, 100, n, hi);
    chk("half0_period", n, 2);
    chk("half0_high", hi, 1);
    @(negedge clk);
    chk("half0_low", 32'({bus.clk_out[1], bus.tick[1]}), 0);
    @(negedge clk);
    chk("half0_high2", 32'({bus.clk_out[1], bus.tick[1]}), 3);
    bus.en = 2'b01;
    @(negedge clk);
    chk("dis_outputs", 32'({bus.clk_out[1], bus.tick[1]}), 0);

    write(1, 781);
    @(negedge clk);
    bus.wr = 1'b0;
    chk("dis_wr_direct", 32'(bus.pending), 0);
    bus.en = 2'b11;
    repeat (100) @(negedge clk);
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
    chk("sync_clk_out", 32'(bus.clk_out), 0);
    chk("sync_tick", 32'(bus.tick), 0);
    wait_tick(0, 2000, n, hi);
    chk("sync_tick_lat", n, 782);
    chk("sync_coincide", 32'(bus.tick), 3);

    write(0, 9);
    @(negedge clk);
    bus.wr = 1'b0;
    chk("pre_rst_pending", 32'(bus.pending), 1);
    chk("pre_rst_high", 32'(bus.clk_out), 3);
    repeat (10) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_clk_out", 32'(bus.clk_out), 0);
    chk("mid_rst_tick", 32'(bus.tick), 0);
    chk("mid_rst_pending", 32'(bus.pending), 0);
    @(negedge clk);
    rst = 1'b1;
    wait_tick(0, 2000, n, hi);
    chk("post_rst_half", n, 783);
    chk("post_rst_pending", 32'(bus.pending), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
